// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout, sum} = a + b + cin, captured when in_valid is high.
// Optional macro FULL_ADDER_OVF_EN adds a registered two's-complement overflow output ovf.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef FULL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             valid_d, valid_q;

  // Plain ripple chain of 1-bit full-adder cells, no lookahead.
  always_comb begin
    carry    = '0;
    sum_comb = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_comb[i]  = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  // Invalid cycles select the held value, so X/Z on the operands cannot leak in.
  always_comb begin
    sum_d   = in_valid ? sum_comb : sum_q;
    cout_d  = in_valid ? carry[WIDTH] : cout_q;
    valid_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

`ifdef FULL_ADDER_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    ovf_d = in_valid ? (carry[WIDTH] ^ carry[WIDTH-1]) : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a WIDTH=1 and a WIDTH=4 instance share clock and reset.
// Overflow checks are compiled in only when FULL_ADDER_OVF_EN is defined.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       iv1, a1, b1, cin1, sum1, cout1, ov1;
  logic       iv4, cin4, cout4, ov4;
  logic [3:0] a4, b4, sum4;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf1, ovf4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .sum       (sum1),
    .cout      (cout1),
`ifdef FULL_ADDER_OVF_EN
    .ovf       (ovf1),
`endif
    .out_valid (ov1)
  );

  full_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .sum       (sum4),
    .cout      (cout4),
`ifdef FULL_ADDER_OVF_EN
    .ovf       (ovf4),
`endif
    .out_valid (ov4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string name, input logic [3:0] exp_sum, input logic exp_cout,
                        input logic exp_valid);
    checks++;
    if ({sum4, cout4, ov4} !== {exp_sum, exp_cout, exp_valid}) begin
      errors++;
      $display("FAIL %s: got sum=%h cout=%b out_valid=%b, want sum=%h cout=%b out_valid=%b",
               name, sum4, cout4, ov4, exp_sum, exp_cout, exp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    iv4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    #50;
    checks++;
    if ({sum1, cout1, ov1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_w1: got %b%b%b want 000", sum1, cout1, ov1);
    end
    check4("reset_w4", 4'h0, 1'b0, 1'b0);
    #50;
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({sum1, cout1, ov1} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle_w1: got %b%b%b want 000", sum1, cout1, ov1);
    end
    check4("post_reset_idle_w4", 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_sweep_w1();
    logic [7:0] sum_tab  = 8'b1001_0110;
    logic [7:0] cout_tab = 8'b1110_1000;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; iv1 = 1'b1;
      tick();
      checks++;
      if ({sum1, cout1, ov1} !== {sum_tab[i], cout_tab[i], 1'b1}) begin
        errors++;
        $display("FAIL sweep_w1[%b]: got sum=%b cout=%b out_valid=%b want %b %b 1",
                 v, sum1, cout1, ov1, sum_tab[i], cout_tab[i]);
      end
    end
    iv1 = 1'b0; a1 = 1'bx; b1 = 1'bz; cin1 = 1'bx;
    tick();
    checks++;
    if ({sum1, cout1, ov1} !== 3'b110) begin
      errors++;
      $display("FAIL hold_w1: got %b%b%b want 110", sum1, cout1, ov1);
    end
    a1 = 0; b1 = 0; cin1 = 0;
  endtask

  task automatic test_boundary_w4();
    iv4 = 1; a4 = 4'hF; b4 = 4'h1; cin4 = 0;
    tick();
    check4("wrap_f_plus_1", 4'h0, 1'b1, 1'b1);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1;
    tick();
    check4("all_ones_cin", 4'hF, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    iv4 = 1; a4 = 4'h5; b4 = 4'h6; cin4 = 0;
    tick();
    check4("b2b_0", 4'hB, 1'b0, 1'b1);
    a4 = 4'h9; b4 = 4'h9; cin4 = 1;
    tick();
    check4("b2b_1", 4'h3, 1'b1, 1'b1);
    a4 = 4'h2; b4 = 4'hA; cin4 = 0;
    tick();
    check4("b2b_2", 4'hC, 1'b0, 1'b1);
  endtask

  task automatic test_hold_w4();
    iv4 = 1; a4 = 4'h3; b4 = 4'h4; cin4 = 1;
    tick();
    check4("load_3_4_1", 4'h8, 1'b0, 1'b1);
    iv4 = 0; a4 = 4'hF; b4 = 4'hF; cin4 = 1;
    tick();
    check4("hold_changed_ops", 4'h8, 1'b0, 1'b0);
    a4 = 4'bx1z0; b4 = 4'hx; cin4 = 1'bz;
    tick();
    check4("hold_x_ops", 4'h8, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    iv4 = 1; a4 = 4'hA; b4 = 4'h7; cin4 = 1;
    tick();
    check4("pre_reset_load", 4'h2, 1'b1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check4("async_reset_now", 4'h0, 1'b0, 1'b0);
    // in_valid still high: the edge during reset must not capture anything
    tick();
    check4("reset_priority", 4'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    iv4 = 1; a4 = 4'h6; b4 = 4'h6; cin4 = 0;
    tick();
    check4("first_after_reset", 4'hC, 1'b0, 1'b1);
    iv4 = 0;
    tick();
    check4("valid_one_pulse", 4'hC, 1'b0, 1'b0);
  endtask

`ifdef FULL_ADDER_OVF_EN
  task automatic test_ovf();
    iv4 = 1; a4 = 4'h7; b4 = 4'h1; cin4 = 0;
    tick();
    check4("ovf_7_1", 4'h8, 1'b0, 1'b1);
    checks++;
    if (ovf4 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_7_1_flag: got %b want 1", ovf4);
    end
    a4 = 4'h8; b4 = 4'h8;
    tick();
    check4("ovf_8_8", 4'h0, 1'b1, 1'b1);
    checks++;
    if (ovf4 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_8_8_flag: got %b want 1", ovf4);
    end
    a4 = 4'h3; b4 = 4'h2;
    tick();
    checks++;
    if (ovf4 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_3_2_flag: got %b want 0", ovf4);
    end
    iv4 = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_sweep_w1();
    test_boundary_w4();
    test_back_to_back();
    test_hold_w4();
    test_async_reset();
`ifdef FULL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered ripple-carry full adder of parameterizable width; the default WIDTH=1 gives a single-bit full adder with a, b, cin, sum and cout.
- Used as the basic arithmetic cell in datapath blocks.
- Outputs are captured on the clock with an input-valid / output-valid qualifier.
- Built as a chain of combinational 1-bit full-adder cells followed by an output register stage.

Parameters:
- WIDTH, 1, operand and sum width in bits; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a, b and cin in the current cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry-out of the MSB.
- out_valid  output  1  high for exactly one cycle when sum/cout hold a new result.

Behaviour:
- Bit cell i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i])
  - c[0] = cin
  - The chain is pure combinational ripple, with no lookahead.
- Result: {cout, sum} = a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
- Reset: while rst_n = 0, immediately and asynchronously force sum = 0, cout = 0, out_valid = 0. Reset has priority over all other inputs.
- Latency: 1 cycle.
  - On a rising edge with in_valid = 1: register sum, cout; set out_valid = 1.
  - On a rising edge with in_valid = 0: sum and cout hold their previous value; out_valid = 0.
- Back-to-back operation: in_valid high on consecutive cycles gives one result per cycle. There is no stall and no backpressure.
- Boundary conditions:
  - All-ones operands with cin = 1: sum = all-ones, cout = 1.
  - Maximum value plus 1 wraps: sum = 0, cout = 1.
- Reset mid-stream: a result captured in the same cycle that rst_n falls is discarded. After rst_n rises, the first valid input produces a result one cycle later.
- Inputs with X/Z while in_valid = 0 must not affect the held outputs.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN
- When defined:
  - Adds output port ovf (1 bit), the registered two's-complement signed overflow: ovf = c[WIDTH] ^ c[WIDTH-1], where c[0] = cin.
  - For WIDTH=1 this reduces to cout ^ cin.
  - Reset value 0; ovf updates and holds under the same in_valid rules as sum.
- When not defined: the ovf port and its logic are absent; the interface is exactly the port list above.

Test Plan:
- WIDTH=1, hold rst_n = 0 with a=b=cin=0 for 100 ns, then release -> sum = 0, cout = 0, out_valid = 0 until the first in_valid.
- WIDTH=1, sweep all 8 {a,b,cin} combinations with in_valid = 1 -> one cycle later:
  - 000 -> sum 0, cout 0
  - 011 -> sum 0, cout 1
  - 100 -> sum 1, cout 0
  - 111 -> sum 1, cout 1
  - out_valid = 1 each cycle.
- WIDTH=4, a = 4'hF, b = 4'h1, cin = 0 -> sum = 4'h0, cout = 1. Then a = 4'hF, b = 4'hF, cin = 1 -> sum = 4'hF, cout = 1.
- WIDTH=4:
  - Apply a = 4'h3, b = 4'h4, cin = 1 with in_valid = 1.
  - Next cycle, drop in_valid and change a, b -> sum stays 4'h8, cout 0, out_valid 0.
- Assert rst_n = 0 mid-stream between clock edges -> sum, cout and out_valid go to 0 immediately without waiting for clk.
- FULL_ADDER_OVF_EN defined, WIDTH=4, a = 4'h7, b = 4'h1, cin = 0 -> sum = 4'h8, cout 0, ovf 1. Then a = 4'h8, b = 4'h8 -> sum 4'h0, cout 1, ovf 1.
